// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling stage: fills S with the identity permutation, then runs the
// 256-step key-dependent swap shuffle over a synchronous-read 256x8 memory port.
module ksa_shuffle (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] secret_key,
  input  logic [7:0]  ram_data,
  output logic [7:0]  ram_addr,
  output logic [7:0]  write_ram_data,
  output logic        write_ram,
  output logic        busy,
  output logic        finish
);

  typedef enum logic [3:0] {
    IDLE, INIT, RD_I, WT_I, CALC_J, RD_J, WT_J, WR_J, WR_I, NEXT, DONE
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  i_r, i_s, j_r, j_s, si_r, si_s, sj_r, sj_s;
  logic [23:0] key_r, key_s;
  logic [1:0]  kidx_r, kidx_s;   // tracks i mod 3 without a divider
  logic [7:0]  kb_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      i_r     <= 8'd0;
      j_r     <= 8'd0;
      si_r    <= 8'd0;
      sj_r    <= 8'd0;
      key_r   <= 24'd0;
      kidx_r  <= 2'd0;
    end else begin
      state_r <= state_s;
      i_r     <= i_s;
      j_r     <= j_s;
      si_r    <= si_s;
      sj_r    <= sj_s;
      key_r   <= key_s;
      kidx_r  <= kidx_s;
    end
  end

  // Key byte selected by i mod 3 (byte 0 is the most significant)
  always_comb begin
    kb_s = 8'd0;
    case (kidx_r)
      2'd0:    kb_s = key_r[23:16];
      2'd1:    kb_s = key_r[15:8];
      2'd2:    kb_s = key_r[7:0];
      default: kb_s = 8'd0;
    endcase
  end

  // Next-state and register update logic
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    si_s    = si_r;
    sj_s    = sj_r;
    key_s   = key_r;
    kidx_s  = kidx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          key_s   = secret_key;
          i_s     = 8'd0;
          kidx_s  = 2'd0;
          state_s = INIT;
        end else begin
          state_s = IDLE;
        end
      end
      INIT: begin
        if (i_r == 8'd255) begin
          i_s     = 8'd0;
          j_s     = 8'd0;
          kidx_s  = 2'd0;
          state_s = RD_I;
        end else begin
          i_s     = i_r + 8'd1;
          state_s = INIT;
        end
      end
      RD_I:   state_s = WT_I;
      WT_I: begin
        si_s    = ram_data;
        state_s = CALC_J;
      end
      CALC_J: begin
        j_s     = j_r + si_r + kb_s;
        state_s = RD_J;
      end
      RD_J:   state_s = WT_J;
      WT_J: begin
        sj_s    = ram_data;
        state_s = WR_J;
      end
      WR_J:   state_s = WR_I;
      WR_I:   state_s = NEXT;
      NEXT: begin
        if (i_r == 8'd255) begin
          state_s = DONE;
        end else begin
          i_s     = i_r + 8'd1;
          kidx_s  = (kidx_r == 2'd2) ? 2'd0 : kidx_r + 2'd1;
          state_s = RD_I;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    ram_addr       = 8'd0;
    write_ram_data = 8'd0;
    write_ram      = 1'b0;
    finish         = 1'b0;
    busy           = (state_r != IDLE);
    case (state_r)
      INIT: begin
        write_ram      = 1'b1;
        ram_addr       = i_r;
        write_ram_data = i_r;
      end
      RD_I: ram_addr = i_r;
      RD_J: ram_addr = j_r;
      WR_J: begin
        write_ram      = 1'b1;
        ram_addr       = j_r;
        write_ram_data = si_r;
      end
      WR_I: begin
        write_ram      = 1'b1;
        ram_addr       = i_r;
        write_ram_data = sj_r;
      end
      DONE:    finish = 1'b1;
      default: ram_addr = 8'd0;
    endcase
  end

endmodule
